// File: rtl/shake_arbiter_if.sv
// Requester-side and core-side signal bundle for the shared SHAKE core arbiter.
// The arbiter takes the slave modport; the requesters/core environment takes master.
interface shake_arbiter_if;
    logic [1:0]   rq_req;
    logic [1:0]   rq_mode0;
    logic [1:0]   rq_mode1;
    logic [7:0]   rq_len0;
    logic [7:0]   rq_len1;
    logic [1:0]   rq_start;
    logic [1:0]   rq_valid;
    logic [127:0] rq_data0;
    logic [127:0] rq_data1;
    logic [1:0]   rq_gnt;
    logic [1:0]   rq_ready;
    logic [1:0]   rq_ovalid;
    logic [127:0] rq_odata;
    logic [1:0]   rq_done;
    logic [1:0]   rq_err;
    logic         busy;
    logic         core_reset;
    logic         core_start;
    logic         core_valid_in;
    logic [127:0] core_data_in;
    logic [1:0]   core_mode;
    logic [7:0]   core_len;
    logic [127:0] core_data_out;
    logic         core_valid_out;
    logic         core_ready_out;
    logic         core_done;

    modport slave (
        input  rq_req, rq_mode0, rq_mode1, rq_len0, rq_len1, rq_start, rq_valid,
               rq_data0, rq_data1, core_data_out, core_valid_out, core_ready_out, core_done,
        output rq_gnt, rq_ready, rq_ovalid, rq_odata, rq_done, rq_err, busy, core_reset,
               core_start, core_valid_in, core_data_in, core_mode, core_len
    );

    modport master (
        output rq_req, rq_mode0, rq_mode1, rq_len0, rq_len1, rq_start, rq_valid,
               rq_data0, rq_data1, core_data_out, core_valid_out, core_ready_out, core_done,
        input  rq_gnt, rq_ready, rq_ovalid, rq_odata, rq_done, rq_err, busy, core_reset,
               core_start, core_valid_in, core_data_in, core_mode, core_len
    );
endinterface

// File: rtl/shake_arbiter.sv
// Round-robin, whole-job arbiter sharing one shake_core between two requesters.
// Grant 1 cycle after req; core traffic forwarded combinationally; 1-cycle core flush after each job.
module shake_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic              clk,
    input  logic              reset,
    shake_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t           state, state_nxt;
    logic             owner;
    logic             last;
    logic             owner_pick;
    logic             grant_fire;
    logic             done_fire;
    logic             tmo_fire;
    logic [CNT_W-1:0] wdog;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic [1:0]       err_q;
    logic [1:0]       mode_q;
    logic [7:0]       len_q;
    logic [1:0]       own_oh;

    assign own_oh = owner ? 2'b10 : 2'b01;

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        done_fire  = 1'b0;
        tmo_fire   = 1'b0;
        // On a tie the requester that did not own the previous job wins.
        owner_pick = (bus.rq_req == 2'b11) ? ~last : bus.rq_req[1];
        case (state)
            IDLE: begin
                if (|bus.rq_req) begin
                    grant_fire = 1'b1;
                    state_nxt  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.core_done) begin
                    done_fire = 1'b1;
                    state_nxt = FLUSH;
                end else if (wdog == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_fire  = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            wdog   <= '0;
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            err_q  <= 2'b00;
            mode_q <= 2'b00;
            len_q  <= 8'd0;
        end else begin
            state  <= state_nxt;
            done_q <= 2'b00;
            err_q  <= 2'b00;
            if (grant_fire) begin
                owner  <= owner_pick;
                gnt_q  <= owner_pick ? 2'b10 : 2'b01;
                mode_q <= owner_pick ? bus.rq_mode1 : bus.rq_mode0;
                len_q  <= owner_pick ? bus.rq_len1 : bus.rq_len0;
                wdog   <= '0;
            end
            if (state == ACTIVE) begin
                wdog <= wdog + 1'b1;
            end
            if (done_fire || tmo_fire) begin
                gnt_q  <= 2'b00;
                last   <= owner;
                done_q <= done_fire ? own_oh : 2'b00;
                err_q  <= tmo_fire ? own_oh : 2'b00;
            end
        end
    end

    always_comb begin
        bus.core_start    = 1'b0;
        bus.core_valid_in = 1'b0;
        bus.core_data_in  = '0;
        bus.rq_ready      = 2'b00;
        bus.rq_ovalid     = 2'b00;
        if (state == ACTIVE) begin
            bus.core_start    = owner ? bus.rq_start[1] : bus.rq_start[0];
            bus.core_valid_in = owner ? bus.rq_valid[1] : bus.rq_valid[0];
            bus.core_data_in  = owner ? bus.rq_data1 : bus.rq_data0;
            bus.rq_ready      = own_oh & {2{bus.core_ready_out}};
            bus.rq_ovalid     = own_oh & {2{bus.core_valid_out}};
        end
    end

    assign bus.rq_odata   = bus.core_data_out;
    assign bus.rq_gnt     = gnt_q;
    assign bus.rq_done    = done_q;
    assign bus.rq_err     = err_q;
    assign bus.busy       = (state != IDLE);
    assign bus.core_reset = reset | (state == FLUSH);
    assign bus.core_mode  = mode_q;
    assign bus.core_len   = len_q;

endmodule

// File: doc/shake_arbiter.md
Name: shake_arbiter

Overview:
- Shares one shake_core between two requesters, e.g. the matrix-A sampler and the CBD noise sampler.
- Arbitrates round-robin with whole-job granularity.
- During a job, latches that requester's mode and length and steers absorb/squeeze traffic to and from the core.
- After every job, and on timeout, pulses a core-only reset so the next job starts from a clean state.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum ACTIVE cycles without core done before the job is aborted.
- CNT_W, 11: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rq_req  in  2  per-requester job request; bit i belongs to requester i
- rq_mode0 / rq_mode1  in  2 each  mode for the job (00 = SHAKE-128, 01 = SHAKE-256)
- rq_len0 / rq_len1  in  8 each  output length in bytes
- rq_start  in  2  first-message-word marker, per requester
- rq_valid  in  2  message word valid, per requester
- rq_data0 / rq_data1  in  128 each  message words
- rq_gnt  out  2  one-hot grant, registered
- rq_ready  out  2  core ready_out routed to the owner only
- rq_ovalid  out  2  core valid_out routed to the owner only
- rq_odata  out  128  core data_out (shared bus; qualify with rq_ovalid)
- rq_done  out  2  one-cycle job-complete pulse to the owner
- rq_err  out  2  one-cycle timeout-abort pulse to the owner
- busy  out  1  high in any state other than IDLE
- core_reset  out  1  to shake_core reset
- core_start, core_valid_in  out  1 each
- core_data_in  out  128
- core_mode  out  2
- core_len  out  8
- core_data_out  in  128
- core_valid_out, core_ready_out, core_done  in  1 each

Behaviour:
- State machine:
  - States: IDLE, ACTIVE, FLUSH.
  - On reset, from any state: go to IDLE.
  - Reset values: rq_gnt=0, rq_done=0, rq_err=0, busy=0, core_mode=0, core_len=0, last pointer=1 (so requester 0 wins the first tie).
  - core_reset = reset OR (state==FLUSH).
- IDLE:
  - If any rq_req bit is high at a clock edge, choose the owner:
    - Only one requester asserting: that one.
    - Both asserting: the requester other than last.
  - Next cycle: state=ACTIVE, rq_gnt[owner]=1, core_mode/core_len latched from the owner's inputs, watchdog cleared.
  - Latency from req to gnt is 1 cycle.
- ACTIVE:
  - Combinational forwarding, owner only:
    - core_start = rq_start[owner], core_valid_in = rq_valid[owner], core_data_in = rq_data[owner].
    - rq_ready[owner] = core_ready_out, rq_ovalid[owner] = core_valid_out.
  - All non-owner outputs are 0, and non-owner inputs are ignored.
  - rq_odata is always core_data_out.
  - core_mode and core_len hold their latched values for the whole job; input changes are ignored until the next grant.
  - The watchdog increments every ACTIVE cycle.
  - On core_done: rq_done[owner] pulses for 1 cycle on the next edge, last<=owner, go to FLUSH.
  - On watchdog == TIMEOUT_CYCLES-1 without core_done: rq_err[owner] pulses, last<=owner, go to FLUSH.
  - If core_done and timeout occur in the same cycle, done wins and there is no err.
  - Deasserting rq_req mid-job has no effect; the job runs to done or timeout.
- FLUSH:
  - Lasts exactly 1 cycle; rq_gnt=0 and core_reset=1.
  - Next state is IDLE.
  - Minimum gap between consecutive grants: done edge → FLUSH → IDLE → grant = 3 cycles.
- Outside ACTIVE:
  - core_start=0, core_valid_in=0, core_data_in=0.
  - core_mode/core_len keep their last latched value (0 after reset).
- Requester contract: drop req within 1 cycle of rq_done or rq_err, otherwise the requester is re-granted. Round-robin then still alternates if both requesters are requesting.

Test Plan:
- Single job: req0, mode 00, len 32, two message words 0x00..0x1F → gnt0 one cycle after req. Core sees mode 00 and len 32. Two 128-bit outputs on rq_ovalid[0] match SHAKE-128 of the message; rq_done[0] pulses once; FLUSH asserts core_reset for exactly 1 cycle.
- Contention: rq_req=11 in the same cycle after reset → requester 0 served first, then requester 1. The 1 job is mode 01, len 32, and its output matches SHAKE-256. rq_ready[1] and rq_ovalid[1] stay 0 throughout job 0.
- Fairness: both requesters hold req for 4 jobs → grant order 0,1,0,1, with a 3-cycle gap between each done and the next gnt.
- Isolation: requester 1 toggles rq_valid and rq_data during requester 0's job → core_data_in reflects requester 0 only; output hash unchanged.
- Timeout: TIMEOUT_CYCLES=16 with a stub core that never asserts done → rq_err[owner] pulses at ACTIVE cycle 16, then FLUSH with core_reset, then IDLE; no rq_done.
- Reset mid-job: assert reset during squeeze → next cycle state IDLE, gnt=0, busy=0, core_reset=1. A new req is granted normally after reset is released.
